// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary to 4-digit BCD converter
// Optional feature macro: BCD_SATURATE_EN (clamp out-of-range operands to 9999).
module bin_to_bcd_seq #(
  parameter int N_BITS = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] bin_in,
  input  logic              start,
  output logic [15:0]       bcd_out,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [3:0] LAST_STEP = 4'(N_BITS - 1);

  state_t            state;
  state_t            state_next;
  logic [N_BITS-1:0] operand;
  logic [15:0]       scratch;
  logic [15:0]       scratch_adj;
  logic [15:0]       result;
  logic [15:0]       bin_ext;
  logic [3:0]        cnt;
  logic              big;

  assign bin_ext = 16'(bin_in);
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Without saturation, digits above the thousands fall off scratch[15].
  always_comb begin
    result = scratch;
`ifdef BCD_SATURATE_EN
    if (big) begin
      result = 16'h9999;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      operand <= '0;
      scratch <= '0;
      cnt     <= '0;
      big     <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= bin_in;
            scratch <= '0;
            cnt     <= '0;
            big     <= (bin_ext > 16'd9999);
          end
        end
        CONV: begin
          {scratch, operand} <= {scratch_adj[14:0], operand, 1'b0};
          cnt                <= cnt + 4'd1;
        end
        DONE: begin
          bcd_out <= result;
          ovf     <= big;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
// Honours BCD_SATURATE_EN when the design is built with it.
module tb_bin_to_bcd_seq;

  localparam int N = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  bin_in = '0;
  logic          start = 1'b0;
  logic [15:0]   bcd_out;
  logic          busy;
  logic          done;
  logic          ovf;

  int n_cmp = 0;
  int n_bad = 0;

  int          edge_n = 0;
  int          acc_edge = 0;
  int          acc_val = 0;
  bit          active = 1'b0;
  logic [15:0] m_bcd = '0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;

  bin_to_bcd_seq #(.N_BITS(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .bin_in  (bin_in),
    .start   (start),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] exp_bcd(input int v);
    int t;
`ifdef BCD_SATURATE_EN
    if (v > 9999) return 16'h9999;
`endif
    t = v % 10000;
    return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request taken when idle yields its result N+1 edges later.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        active = 1'b0;
        m_bcd  = '0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
      end else begin
        edge_n++;
        m_done = 1'b0;
        if (active && edge_n == acc_edge + N + 1) begin
          m_bcd  = exp_bcd(acc_val);
          m_ovf  = (acc_val > 9999);
          m_done = 1'b1;
          active = 1'b0;
        end else if (!active && start) begin
          active   = 1'b1;
          acc_edge = edge_n;
          acc_val  = int'(bin_in);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("cyc_bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("cyc_busy", 32'(busy), 32'(active));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic go(input int v, output int k);
    @(posedge clock);
    #2;
    bin_in = N'(v);
    start  = 1'b1;
    @(posedge clock);
    #1;
    k = edge_n;
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int at_edge);
    bit seen;
    seen    = 1'b0;
    at_edge = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (done) begin
        seen    = 1'b1;
        at_edge = edge_n;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no done pulse within 40 cycles", name);
    end
  endtask

  task automatic conv(input string name, input int v, input logic [15:0] bcd_x, input logic ovf_x);
    int k;
    int e;
    go(v, k);
    wait_done(name, e);
    chk({name, "_latency"}, 32'(e - k), 32'd15);
    chk({name, "_bcd"}, 32'(bcd_out), 32'(bcd_x));
    chk({name, "_ovf"}, 32'(ovf), 32'(ovf_x));
  endtask

  initial begin
    int k;
    int e;
    int dones;
    logic [15:0] seen_bcd;

    repeat (2) @(negedge clock);
    chk("rst_bcd_out", 32'(bcd_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    go(1234, k);
    chk("t1234_busy_early", 32'(busy), 32'h1);
    chk("t1234_done_early", 32'(done), 32'h0);
    wait_done("t1234", e);
    chk("t1234_latency", 32'(e - k), 32'd15);
    chk("t1234_bcd", 32'(bcd_out), 32'h1234);
    chk("t1234_ovf", 32'(ovf), 32'h0);

    conv("t0", 0, 16'h0000, 1'b0);
    conv("t9999", 9999, 16'h9999, 1'b0);
    conv("t1000", 1000, 16'h1000, 1'b0);
`ifdef BCD_SATURATE_EN
    conv("t12345", 12345, 16'h9999, 1'b1);
    conv("t10000", 10000, 16'h9999, 1'b1);
    conv("t16383", 16383, 16'h9999, 1'b1);
`else
    conv("t12345", 12345, 16'h2345, 1'b1);
    conv("t10000", 10000, 16'h0000, 1'b1);
    conv("t16383", 16383, 16'h6383, 1'b1);
`endif

    // start held high across two back-to-back conversions
    @(posedge clock);
    #2;
    bin_in = N'(42);
    start  = 1'b1;
    @(posedge clock);
    #1;
    k = edge_n;
    repeat (5) @(posedge clock);
    #2;
    bin_in = N'(77);
    wait_done("held_first", e);
    chk("held_first_edge", 32'(e - k), 32'd15);
    chk("held_first_bcd", 32'(bcd_out), 32'h0042);
    wait_done("held_second", e);
    start = 1'b0;
    chk("held_second_edge", 32'(e - k), 32'd31);
    chk("held_second_bcd", 32'(bcd_out), 32'h0077);
    repeat (3) @(posedge clock);

    // reset in the middle of a conversion
    go(5678, k);
    repeat (6) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_bcd_out", 32'(bcd_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'h0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    conv("t5678_after_rst", 5678, 16'h5678, 1'b0);

    // a start pulse during conversion is ignored
    go(321, k);
    repeat (2) @(posedge clock);
    #2;
    bin_in = N'(999);
    start  = 1'b1;
    @(posedge clock);
    #2;
    start    = 1'b0;
    dones    = 0;
    seen_bcd = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        seen_bcd = bcd_out;
      end
      if (edge_n == k + 16) chk("ign_busy_k16", 32'(busy), 32'h0);
    end
    chk("ign_done_count", 32'(dones), 32'd1);
    chk("ign_bcd", 32'(seen_bcd), 32'h0321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
